reservation_station: RTL and testbench

Out-of-order issue buffer that receives the decoder's register-operand instructions from the dispatch stage. Non-load/store ops only. Each entry holds up to two operands, either as values or as ROB tags. Entries wake up on ALU and LSB CDB broadcasts, and one ready entry per cycle is sent to the ALU. The block reports a free slot and its ready status back to dispatch, closing the dispatch↔RS handshake.

---
 rtl/reservation_station.sv | 185 ++++++++++++++++++
 tb/tb_reservation_station.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Out-of-order issue buffer for register-operand ALU ops: CDB wakeup, dispatch bypass, lowest-index select.
// Optional feature macro: RS_DIRECT_ISSUE_EN (issue a fully-ready dispatch straight to the ALU when nothing stored is ready).
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 4,
    localparam int IDX_W    = $clog2(RS_SIZE)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 dis_flag_in,
    input  logic [5:0]           dis_op_in,
    input  logic [31:0]          dis_imm_in,
    input  logic [31:0]          dis_pc_in,
    input  logic [31:0]          dis_btb_pc_in,
    input  logic                 dis_btb_predict_in,
    input  logic [ROB_IDX_W-1:0] dis_rob_idx_in,
    input  logic                 dis_r1_in,
    input  logic                 dis_r2_in,
    input  logic [31:0]          dis_v1_in,
    input  logic [31:0]          dis_v2_in,
    output logic [IDX_W-1:0]     put_idx_out,
    output logic                 full_out,
    output logic                 ready_out,
    output logic [IDX_W-1:0]     ready_idx_out,
    input  logic                 alu_cdb_flag_in,
    input  logic [ROB_IDX_W-1:0] alu_cdb_rob_idx_in,
    input  logic [31:0]          alu_cdb_val_in,
    input  logic                 lsb_cdb_flag_in,
    input  logic [ROB_IDX_W-1:0] lsb_cdb_rob_idx_in,
    input  logic [31:0]          lsb_cdb_val_in,
    output logic                 issue_flag_out,
    output logic [5:0]           issue_op_out,
    output logic [31:0]          issue_v1_out,
    output logic [31:0]          issue_v2_out,
    output logic [31:0]          issue_imm_out,
    output logic [31:0]          issue_pc_out,
    output logic [31:0]          issue_btb_pc_out,
    output logic                 issue_btb_predict_out,
    output logic [ROB_IDX_W-1:0] issue_rob_idx_out
);

    typedef struct packed {
        logic [5:0]           op;
        logic                 r1;
        logic [31:0]          v1;
        logic                 r2;
        logic [31:0]          v2;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [31:0]          btb_pc;
        logic                 btb_predict;
        logic [ROB_IDX_W-1:0] rob_idx;
    } entry_t;

    logic [RS_SIZE-1:0] r_busy;
    entry_t             r_ent [RS_SIZE];

    logic               w_full, w_ready;
    logic [IDX_W-1:0]   w_put_idx, w_ready_idx;
    logic [32:0]        w_dis_op1, w_dis_op2;
    logic               w_direct;
    entry_t             w_new;

    // Returns {ready, value}; a pending operand captures a matching CDB, ALU first.
    function automatic logic [32:0] snoop(
        input logic r, input logic [31:0] v,
        input logic af, input logic [ROB_IDX_W-1:0] at, input logic [31:0] av,
        input logic lf, input logic [ROB_IDX_W-1:0] lt, input logic [31:0] lv);
        logic [32:0] res;
        res = {r, v};
        if (!r) begin
            if (af && at == v[ROB_IDX_W-1:0])      res = {1'b1, av};
            else if (lf && lt == v[ROB_IDX_W-1:0]) res = {1'b1, lv};
        end
        return res;
    endfunction

    always_comb begin
        w_put_idx   = '0;
        w_full      = 1'b1;
        w_ready_idx = '0;
        w_ready     = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_put_idx = IDX_W'(i);
                w_full    = 1'b0;
            end
            if (r_busy[i] && r_ent[i].r1 && r_ent[i].r2) begin
                w_ready_idx = IDX_W'(i);
                w_ready     = 1'b1;
            end
        end
    end

    assign w_dis_op1 = snoop(dis_r1_in, dis_v1_in, alu_cdb_flag_in, alu_cdb_rob_idx_in, alu_cdb_val_in,
                             lsb_cdb_flag_in, lsb_cdb_rob_idx_in, lsb_cdb_val_in);
    assign w_dis_op2 = snoop(dis_r2_in, dis_v2_in, alu_cdb_flag_in, alu_cdb_rob_idx_in, alu_cdb_val_in,
                             lsb_cdb_flag_in, lsb_cdb_rob_idx_in, lsb_cdb_val_in);

    always_comb begin
        w_new             = '0;
        w_new.op          = dis_op_in;
        w_new.r1          = w_dis_op1[32];
        w_new.v1          = w_dis_op1[31:0];
        w_new.r2          = w_dis_op2[32];
        w_new.v2          = w_dis_op2[31:0];
        w_new.imm         = dis_imm_in;
        w_new.pc          = dis_pc_in;
        w_new.btb_pc      = dis_btb_pc_in;
        w_new.btb_predict = dis_btb_predict_in;
        w_new.rob_idx     = dis_rob_idx_in;
    end

`ifdef RS_DIRECT_ISSUE_EN
    assign w_direct = dis_flag_in && w_new.r1 && w_new.r2 && !w_ready;
`else
    assign w_direct = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy                <= '0;
            for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
            issue_flag_out        <= 1'b0;
            issue_op_out          <= '0;
            issue_v1_out          <= '0;
            issue_v2_out          <= '0;
            issue_imm_out         <= '0;
            issue_pc_out          <= '0;
            issue_btb_pc_out      <= '0;
            issue_btb_predict_out <= 1'b0;
            issue_rob_idx_out     <= '0;
        end else if (clear_in) begin
            r_busy         <= '0;
            issue_flag_out <= 1'b0;
        end else if (!rdy_in) begin
            issue_flag_out <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    {r_ent[i].r1, r_ent[i].v1} <= snoop(r_ent[i].r1, r_ent[i].v1,
                        alu_cdb_flag_in, alu_cdb_rob_idx_in, alu_cdb_val_in,
                        lsb_cdb_flag_in, lsb_cdb_rob_idx_in, lsb_cdb_val_in);
                    {r_ent[i].r2, r_ent[i].v2} <= snoop(r_ent[i].r2, r_ent[i].v2,
                        alu_cdb_flag_in, alu_cdb_rob_idx_in, alu_cdb_val_in,
                        lsb_cdb_flag_in, lsb_cdb_rob_idx_in, lsb_cdb_val_in);
                end
            end
            issue_flag_out <= w_ready || w_direct;
            if (w_ready) begin
                issue_op_out          <= r_ent[w_ready_idx].op;
                issue_v1_out          <= r_ent[w_ready_idx].v1;
                issue_v2_out          <= r_ent[w_ready_idx].v2;
                issue_imm_out         <= r_ent[w_ready_idx].imm;
                issue_pc_out          <= r_ent[w_ready_idx].pc;
                issue_btb_pc_out      <= r_ent[w_ready_idx].btb_pc;
                issue_btb_predict_out <= r_ent[w_ready_idx].btb_predict;
                issue_rob_idx_out     <= r_ent[w_ready_idx].rob_idx;
                r_busy[w_ready_idx]   <= 1'b0;
            end else if (w_direct) begin
                issue_op_out          <= w_new.op;
                issue_v1_out          <= w_new.v1;
                issue_v2_out          <= w_new.v2;
                issue_imm_out         <= w_new.imm;
                issue_pc_out          <= w_new.pc;
                issue_btb_pc_out      <= w_new.btb_pc;
                issue_btb_predict_out <= w_new.btb_predict;
                issue_rob_idx_out     <= w_new.rob_idx;
            end
            // put_idx never points at a busy slot, so a slot issuing now is not reused this edge.
            if (dis_flag_in && !w_full && !w_direct) begin
                r_busy[w_put_idx] <= 1'b1;
                r_ent[w_put_idx]  <= w_new;
            end
        end
    end

    assign put_idx_out   = w_put_idx;
    assign full_out      = w_full;
    assign ready_out     = w_ready;
    assign ready_idx_out = w_ready_idx;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (default build): allocate, wakeup, bypass, full, clear, stall.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        dis_flag_in, dis_btb_predict_in, dis_r1_in, dis_r2_in;
    logic [5:0]  dis_op_in;
    logic [31:0] dis_imm_in, dis_pc_in, dis_btb_pc_in, dis_v1_in, dis_v2_in;
    logic [3:0]  dis_rob_idx_in;
    logic [3:0]  put_idx_out, ready_idx_out;
    logic        full_out, ready_out;
    logic        alu_cdb_flag_in, lsb_cdb_flag_in;
    logic [3:0]  alu_cdb_rob_idx_in, lsb_cdb_rob_idx_in;
    logic [31:0] alu_cdb_val_in, lsb_cdb_val_in;
    logic        issue_flag_out, issue_btb_predict_out;
    logic [5:0]  issue_op_out;
    logic [31:0] issue_v1_out, issue_v2_out, issue_imm_out, issue_pc_out, issue_btb_pc_out;
    logic [3:0]  issue_rob_idx_out;

    int n_chk = 0;
    int n_err = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .dis_flag_in(dis_flag_in), .dis_op_in(dis_op_in), .dis_imm_in(dis_imm_in),
        .dis_pc_in(dis_pc_in), .dis_btb_pc_in(dis_btb_pc_in),
        .dis_btb_predict_in(dis_btb_predict_in), .dis_rob_idx_in(dis_rob_idx_in),
        .dis_r1_in(dis_r1_in), .dis_r2_in(dis_r2_in), .dis_v1_in(dis_v1_in), .dis_v2_in(dis_v2_in),
        .put_idx_out(put_idx_out), .full_out(full_out), .ready_out(ready_out),
        .ready_idx_out(ready_idx_out),
        .alu_cdb_flag_in(alu_cdb_flag_in), .alu_cdb_rob_idx_in(alu_cdb_rob_idx_in),
        .alu_cdb_val_in(alu_cdb_val_in),
        .lsb_cdb_flag_in(lsb_cdb_flag_in), .lsb_cdb_rob_idx_in(lsb_cdb_rob_idx_in),
        .lsb_cdb_val_in(lsb_cdb_val_in),
        .issue_flag_out(issue_flag_out), .issue_op_out(issue_op_out),
        .issue_v1_out(issue_v1_out), .issue_v2_out(issue_v2_out),
        .issue_imm_out(issue_imm_out), .issue_pc_out(issue_pc_out),
        .issue_btb_pc_out(issue_btb_pc_out), .issue_btb_predict_out(issue_btb_predict_out),
        .issue_rob_idx_out(issue_rob_idx_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dis(input logic r1, input logic [31:0] v1, input logic r2,
                       input logic [31:0] v2, input logic [3:0] rob);
        dis_flag_in    = 1'b1;
        dis_r1_in      = r1;
        dis_v1_in      = v1;
        dis_r2_in      = r2;
        dis_v2_in      = v2;
        dis_rob_idx_in = rob;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        dis_flag_in = 1'b0; dis_op_in = 6'd1; dis_imm_in = 32'h0; dis_pc_in = 32'h100;
        dis_btb_pc_in = 32'h0; dis_btb_predict_in = 1'b0; dis_rob_idx_in = '0;
        dis_r1_in = 1'b0; dis_r2_in = 1'b0; dis_v1_in = '0; dis_v2_in = '0;
        alu_cdb_flag_in = 1'b0; alu_cdb_rob_idx_in = '0; alu_cdb_val_in = '0;
        lsb_cdb_flag_in = 1'b0; lsb_cdb_rob_idx_in = '0; lsb_cdb_val_in = '0;
        tick(); tick();
        check("rst_full", 32'(full_out), 0);
        check("rst_put", 32'(put_idx_out), 0);
        check("rst_ready", 32'(ready_out), 0);
        check("rst_ridx", 32'(ready_idx_out), 0);
        check("rst_iflag", 32'(issue_flag_out), 0);
        check("rst_iv1", issue_v1_out, 0);
        rst_in = 1'b1;
        tick();

        // Ready ADD: 2-edge latency
        dis(1, 5, 1, 7, 3);
        #1 check("add_put_before", 32'(put_idx_out), 0);
        tick();
        dis_flag_in = 1'b0;
        #1;
        check("add_iflag_e", 32'(issue_flag_out), 0);
        check("add_ready", 32'(ready_out), 1);
        check("add_put_after", 32'(put_idx_out), 1);
        tick();
        check("add_iflag", 32'(issue_flag_out), 1);
        check("add_v1", issue_v1_out, 5);
        check("add_v2", issue_v2_out, 7);
        check("add_rob", 32'(issue_rob_idx_out), 3);
        check("add_pc", issue_pc_out, 32'h100);
        check("add_freed", 32'(put_idx_out), 0);
        tick();
        check("add_iflag_off", 32'(issue_flag_out), 0);
        check("add_v1_hold", issue_v1_out, 5);

        // Pending operand woken by ALU CDB
        dis(0, 6, 1, 1, 4);
        tick();
        dis_flag_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wait_noissue", 32'(issue_flag_out), 0);
        end
        alu_cdb_flag_in = 1'b1; alu_cdb_rob_idx_in = 4'd6; alu_cdb_val_in = 32'h1234;
        tick();
        alu_cdb_flag_in = 1'b0;
        #1 check("wake_ready", 32'(ready_out), 1);
        tick();
        check("wake_iflag", 32'(issue_flag_out), 1);
        check("wake_v1", issue_v1_out, 32'h1234);
        check("wake_rob", 32'(issue_rob_idx_out), 4);
        tick();

        // Dispatch bypass from LSB CDB
        dis(1, 1, 0, 2, 5);
        lsb_cdb_flag_in = 1'b1; lsb_cdb_rob_idx_in = 4'd2; lsb_cdb_val_in = 32'd9;
        tick();
        dis_flag_in = 1'b0; lsb_cdb_flag_in = 1'b0;
        #1 check("byp_ready", 32'(ready_out), 1);
        tick();
        check("byp_iflag", 32'(issue_flag_out), 1);
        check("byp_v2", issue_v2_out, 9);
        check("byp_rob", 32'(issue_rob_idx_out), 5);
        tick();

        // Fill all 16 entries with entry i waiting on tag i
        for (int i = 0; i < 16; i++) begin
            dis(0, 32'(i), 1, 0, 4'(i));
            tick();
        end
        dis_flag_in = 1'b0;
        #1;
        check("full", 32'(full_out), 1);
        check("full_ready", 32'(ready_out), 0);
        dis(1, 32'hdead, 1, 32'hbeef, 4'd15);
        tick();
        dis_flag_in = 1'b0;
        #1 check("full_ignored", 32'(ready_out), 0);
        alu_cdb_flag_in = 1'b1; alu_cdb_rob_idx_in = 4'd5; alu_cdb_val_in = 32'h55;
        lsb_cdb_flag_in = 1'b1; lsb_cdb_rob_idx_in = 4'd2; lsb_cdb_val_in = 32'h22;
        tick();
        alu_cdb_flag_in = 1'b0; lsb_cdb_flag_in = 1'b0;
        #1 check("two_ridx", 32'(ready_idx_out), 2);
        tick();
        check("first_rob", 32'(issue_rob_idx_out), 2);
        check("first_v1", issue_v1_out, 32'h22);
        check("first_full", 32'(full_out), 0);
        check("first_put", 32'(put_idx_out), 2);
        tick();
        check("second_flag", 32'(issue_flag_out), 1);
        check("second_rob", 32'(issue_rob_idx_out), 5);
        check("second_v1", issue_v1_out, 32'h55);

        // Clear overrides a same-edge dispatch
        dis(1, 1, 1, 1, 7);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0; dis_flag_in = 1'b0;
        #1;
        check("clr_full", 32'(full_out), 0);
        check("clr_put", 32'(put_idx_out), 0);
        check("clr_ready", 32'(ready_out), 0);
        check("clr_iflag", 32'(issue_flag_out), 0);

        // Stall holds a ready entry and ignores dispatch
        dis(1, 32'ha, 1, 32'hb, 9);
        tick();
        dis(1, 32'hc, 1, 32'hd, 10);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_noissue", 32'(issue_flag_out), 0);
        end
        dis_flag_in = 1'b0;
        #1 check("stall_put", 32'(put_idx_out), 1);
        rdy_in = 1'b1;
        tick();
        check("stall_iflag", 32'(issue_flag_out), 1);
        check("stall_rob", 32'(issue_rob_idx_out), 9);
        tick();
        check("stall_after", 32'(issue_flag_out), 0);
        check("stall_empty", 32'(ready_out), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
